// File: rtl/iob_req_reg.sv
// Registered, transaction-locking request stage between the priority merge and one slave.
// Optional slave-response watchdog enabled by defining IOB_REQ_REG_TIMEOUT_EN.
module iob_req_reg #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W+DATA_W+DATA_W/8:0]  m_req,
    output logic [DATA_W:0]                  m_resp,
    output logic [ADDR_W+DATA_W+DATA_W/8:0]  s_req,
    input  logic [DATA_W:0]                  s_resp,
    output logic                             timeout_err
);

    localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int RESP_W = DATA_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [REQ_W-1:0]  s_req_r;
    logic [RESP_W-1:0] m_resp_r;
    logic              m_valid_s;
    logic              s_ready_s;
    logic              timeout_hit_s;

    assign m_valid_s = m_req[REQ_W-1];
    assign s_ready_s = s_resp[0];

`ifdef IOB_REQ_REG_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    logic [15:0] wdog_cnt_r;
    logic        timeout_err_r;

    // The limit is reached on the TIMEOUT-th stalled BUSY cycle; a ready in that cycle wins.
    assign timeout_hit_s = (state_r == ST_BUSY) && !s_ready_s && (wdog_cnt_r == TIMEOUT_M1);
    assign timeout_err   = timeout_err_r;

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_r    <= 16'd0;
            timeout_err_r <= 1'b0;
        end else begin
            if (state_r == ST_IDLE) begin
                wdog_cnt_r <= 16'd0;
            end else if ((state_r == ST_BUSY) && !s_ready_s) begin
                wdog_cnt_r <= wdog_cnt_r + 16'd1;
            end else begin
                wdog_cnt_r <= wdog_cnt_r;
            end
            if (timeout_hit_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // Next-state decode for the IDLE/BUSY/DONE transaction FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (m_valid_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (s_ready_s || timeout_hit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State plus output registers; s_req_r is the request register, m_resp_r holds rdata_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            s_req_r  <= {REQ_W{1'b0}};
            m_resp_r <= {RESP_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    m_resp_r <= {RESP_W{1'b0}};
                    if (m_valid_s) begin
                        s_req_r <= {1'b1, m_req[REQ_W-2:0]};
                    end else begin
                        s_req_r <= {REQ_W{1'b0}};
                    end
                end
                ST_BUSY: begin
                    if (s_ready_s) begin
                        s_req_r  <= {REQ_W{1'b0}};
                        m_resp_r <= {s_resp[DATA_W:1], 1'b1};
                    end else if (timeout_hit_s) begin
                        // Abandoned transaction answers with zero data.
                        s_req_r  <= {REQ_W{1'b0}};
                        m_resp_r <= {{DATA_W{1'b0}}, 1'b1};
                    end else begin
                        s_req_r  <= s_req_r;
                        m_resp_r <= {RESP_W{1'b0}};
                    end
                end
                ST_DONE: begin
                    s_req_r  <= {REQ_W{1'b0}};
                    m_resp_r <= {RESP_W{1'b0}};
                end
                default: begin
                    s_req_r  <= {REQ_W{1'b0}};
                    m_resp_r <= {RESP_W{1'b0}};
                end
            endcase
        end
    end

    assign s_req  = s_req_r;
    assign m_resp = m_resp_r;

endmodule

// File: tb/tb_iob_req_reg.sv
// Scoreboard bench for iob_req_reg: stimulus queues expected s_req/m_resp events, a monitor checks them.
// Timeout scenarios run when IOB_REQ_REG_TIMEOUT_EN is defined.
module tb_iob_req_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [68:0] m_req;
    logic [32:0] m_resp;
    logic [68:0] s_req;
    logic [32:0] s_resp;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit started  = 1'b0;

    typedef struct {
        int          cyc;
        logic [67:0] body;
    } req_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
    } resp_exp_t;

    req_exp_t  sq[$];
    resp_exp_t rq[$];

    iob_req_reg #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_req       (m_req),
        .m_resp      (m_resp),
        .s_req       (s_req),
        .s_resp      (s_resp),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        m_req = {v, a, d, s};
    endtask

    task automatic exp_sreq(input int c, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_exp_t e;
        e.cyc  = c;
        e.body = {a, d, s};
        sq.push_back(e);
    endtask

    task automatic exp_resp(input int c, input logic [31:0] r);
        resp_exp_t e;
        e.cyc   = c;
        e.rdata = r;
        rq.push_back(e);
    endtask

    // Monitor: pops expectations when the DUT presents s_req.valid or m_resp.ready.
    logic        prev_valid = 1'b0;
    logic [67:0] lock_body  = 68'd0;
    always @(negedge clk) begin
        if (started) begin
            if (s_req[68] && !prev_valid) begin
                if (sq.size() == 0) begin
                    check("unexpected_sreq_valid", s_req, 69'd0);
                end else begin
                    req_exp_t e;
                    e = sq.pop_front();
                    check("sreq_cycle", 69'(cyc), 69'(e.cyc));
                    check("sreq_body", {1'b0, s_req[67:0]}, {1'b0, e.body});
                    lock_body = e.body;
                end
            end else if (s_req[68] && prev_valid) begin
                check("sreq_lock", {1'b0, s_req[67:0]}, {1'b0, lock_body});
            end else begin
                check("sreq_idle_zero", s_req, 69'd0);
            end
            prev_valid = s_req[68];

            if (m_resp[0]) begin
                if (rq.size() == 0) begin
                    check("unexpected_mresp_ready", {36'd0, m_resp}, 69'd0);
                end else begin
                    resp_exp_t r;
                    r = rq.pop_front();
                    check("mresp_cycle", 69'(cyc), 69'(r.cyc));
                    check("mresp_rdata", {37'd0, m_resp[32:1]}, {37'd0, r.rdata});
                end
            end else begin
                check("mresp_idle_zero", {36'd0, m_resp}, 69'd0);
            end
        end
    end

    initial begin
        int t0;
        rst    = 1'b1;
        m_req  = 69'd0;
        s_resp = 33'd0;
        step(2);
        check("reset_sreq", s_req, 69'd0);
        check("reset_mresp", {36'd0, m_resp}, 69'd0);
        check("reset_timeout_err", {68'd0, timeout_err}, 69'd0);
        rst = 1'b0;
        step(1);
        started = 1'b1;

        // Single read
        t0 = cyc;
        set_req(1'b1, 32'h0000_0100, 32'h0, 4'h0);
        exp_sreq(t0 + 1, 32'h0000_0100, 32'h0, 4'h0);
        step(1);
        set_req(1'b0, 32'h0, 32'h0, 4'h0);
        s_resp = {32'hCAFE_F00D, 1'b1};
        exp_resp(t0 + 2, 32'hCAFE_F00D);
        step(1);
        s_resp = 33'd0;
        check("single_sreq_drop", {68'd0, s_req[68]}, 69'd0);
        step(2);

        // Request lock: merge changes addr while the slave stalls
        t0 = cyc;
        set_req(1'b1, 32'h0000_0100, 32'h0, 4'h0);
        exp_sreq(t0 + 1, 32'h0000_0100, 32'h0, 4'h0);
        step(2);
        set_req(1'b1, 32'h0000_0200, 32'h0, 4'h0);
        step(3);
        s_resp = {32'h1234_5678, 1'b1};
        exp_resp(t0 + 6, 32'h1234_5678);
        step(1);
        s_resp = 33'd0;
        set_req(1'b0, 32'h0, 32'h0, 4'h0);
        step(2);

        // Back-to-back writes, valid held high, slave always ready
        t0 = cyc;
        s_resp = {32'hA5A5_0000, 1'b1};
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 32'h0000_1000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'hF);
            exp_sreq(t0 + 3 * i + 1, 32'h0000_1000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'hF);
            exp_resp(t0 + 3 * i + 2, 32'hA5A5_0000 + 32'(i));
            step(1);
            s_resp = {32'hA5A5_0000 + 32'(i), 1'b1};
            step(1);
            s_resp = {32'hA5A5_0000, 1'b1};
            step(1);
        end
        set_req(1'b0, 32'h0, 32'h0, 4'h0);
        s_resp = 33'd0;
        step(2);

        // Reset mid-BUSY
        t0 = cyc;
        set_req(1'b1, 32'h0000_0300, 32'h0, 4'h0);
        exp_sreq(t0 + 1, 32'h0000_0300, 32'h0, 4'h0);
        step(1);
        set_req(1'b0, 32'h0, 32'h0, 4'h0);
        step(1);
        rst = 1'b1;
        step(1);
        check("rst_mid_sreq", s_req, 69'd0);
        check("rst_mid_mresp", {36'd0, m_resp}, 69'd0);
        rst = 1'b0;
        step(1);
        set_req(1'b1, 32'h0000_0400, 32'h0, 4'h0);
        exp_sreq(t0 + 5, 32'h0000_0400, 32'h0, 4'h0);
        step(1);
        set_req(1'b0, 32'h0, 32'h0, 4'h0);
        s_resp = {32'h0BAD_CAFE, 1'b1};
        exp_resp(t0 + 6, 32'h0BAD_CAFE);
        step(1);
        s_resp = 33'd0;
        step(2);

`ifdef IOB_REQ_REG_TIMEOUT_EN
        // Boundary: ready on the 4th BUSY cycle is a normal completion
        t0 = cyc;
        set_req(1'b1, 32'h0000_0500, 32'h0, 4'h0);
        exp_sreq(t0 + 1, 32'h0000_0500, 32'h0, 4'h0);
        step(1);
        set_req(1'b0, 32'h0, 32'h0, 4'h0);
        step(3);
        s_resp = {32'hBEEF_0001, 1'b1};
        exp_resp(t0 + 5, 32'hBEEF_0001);
        step(1);
        s_resp = 33'd0;
        step(1);
        check("boundary_no_err", {68'd0, timeout_err}, 69'd0);
        step(1);

        // Timeout: slave never ready
        t0 = cyc;
        set_req(1'b1, 32'h0000_0600, 32'h0, 4'h0);
        exp_sreq(t0 + 1, 32'h0000_0600, 32'h0, 4'h0);
        s_resp = {32'hDEAD_BEEF, 1'b0};
        step(1);
        set_req(1'b0, 32'h0, 32'h0, 4'h0);
        exp_resp(t0 + 5, 32'h0);
        step(3);
        check("timeout_err_before", {68'd0, timeout_err}, 69'd0);
        step(1);
        check("timeout_err_set", {68'd0, timeout_err}, 69'd1);
        step(6);
        check("timeout_err_sticky", {68'd0, timeout_err}, 69'd1);
        s_resp = 33'd0;
        rst = 1'b1;
        step(1);
        check("timeout_err_rst", {68'd0, timeout_err}, 69'd0);
        rst = 1'b0;
        step(1);
`else
        // Without the watchdog a stalled slave keeps BUSY indefinitely
        t0 = cyc;
        set_req(1'b1, 32'h0000_0700, 32'h0, 4'h0);
        exp_sreq(t0 + 1, 32'h0000_0700, 32'h0, 4'h0);
        step(1);
        set_req(1'b0, 32'h0, 32'h0, 4'h0);
        step(11);
        check("stall_still_valid", {68'd0, s_req[68]}, 69'd1);
        check("stall_no_err", {68'd0, timeout_err}, 69'd0);
        s_resp = {32'h7777_8888, 1'b1};
        exp_resp(t0 + 13, 32'h7777_8888);
        step(1);
        s_resp = 33'd0;
        step(2);
`endif

        step(3);
        check("sreq_queue_empty", 69'(sq.size()), 69'd0);
        check("mresp_queue_empty", 69'(rq.size()), 69'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iob_req_reg.md
# iob_req_reg

Registered, transaction-locking request stage placed directly downstream of the priority merge and upstream of a single slave. It captures the merged request when `valid` rises and presents a stable, registered copy to the slave until the slave answers. It then returns the registered response to the merge for exactly one cycle. This cuts the combinational path from the masters to the slave and keeps a mid-transaction priority change at the merge from altering the request seen by the slave.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; multiple of 8
- `TIMEOUT`, 255, slave-response watchdog limit in cycles, range 1..65535; used only with the timeout feature

Derived widths:
- Request width: `1+ADDR_W+DATA_W+DATA_W/8`, default 69; packed `{valid, addr, wdata, wstrb}`, `valid` at MSB
- Response width: `DATA_W+1`, default 33; packed `{rdata, ready}`, `ready` at LSB

Ports:
- `clk`  in  1  clock; single clock domain, all state on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `m_req`  in  request width  request from the merge output
- `m_resp`  out  response width  response to the merge
- `s_req`  out  request width  registered request to the slave
- `s_resp`  in  response width  response from the slave
- `timeout_err`  out  1  sticky watchdog error flag

## Operation
- The FSM has three states: IDLE, BUSY and DONE. All outputs are registered or decoded from registers only; there is no combinational path from an input to an output.
- **IDLE**
  - `s_req` and `m_resp` are all zero.
  - If `m_req.valid`=1, latch `addr`, `wdata` and `wstrb` into the request register and go to BUSY.
- **BUSY**
  - `s_req` = `{1, addr_r, wdata_r, wstrb_r}`.
  - `m_req` is ignored; changes at the merge do not alter `s_req`.
  - If `s_resp.ready`=1, latch `s_resp.rdata` into `rdata_r` and go to DONE.
- **DONE**
  - `s_req.valid`=0.
  - `m_resp` = `{rdata_r, 1}` for exactly this one cycle.
  - Go to IDLE unconditionally.
  - `m_req` is ignored, because it still carries the request being answered.
- **Read and write**
  - `wstrb`=0 is a read.
  - `rdata_r` is latched on every completion, reads and writes alike.
  - On a write, the master ignores `rdata`.
- **Reset**
  - Applies in any state: next state is IDLE; request register, `rdata_r`, watchdog counter and `timeout_err` are cleared.
  - A slave transaction in flight is abandoned, and the master receives no `ready`.
- **Reset values:** `s_req`=0, `m_resp`=0, `timeout_err`=0.

## Timing
- A request first seen at cycle *t* in IDLE gives `s_req.valid`=1 from *t+1*.
- If the slave asserts `ready` in cycle *k* (k ≥ t+1):
  - `m_resp.ready`=1 in *k+1*.
  - `s_req.valid`=0 from *k+1*.
- Minimum master-visible latency: 2 cycles from `valid` to `ready`.
- Minimum back-to-back period: 3 cycles per transaction. The next request is sampled in the IDLE cycle *k+2*.
- `s_req` holds constant for the whole BUSY interval, so it satisfies the slave's valid-hold rule.
- If `m_req.valid` is still high in IDLE after DONE, it is treated as a new request.
- `s_resp.ready` is ignored outside BUSY.

## Configuration
- **Macro:** `IOB_REQ_REG_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle in which `s_resp.ready`=0.
  - If the counter reaches `TIMEOUT` with `ready` still 0, go to DONE with `rdata_r`=0 and set `timeout_err`=1.
  - `timeout_err` stays set until `rst`.
  - A `ready` in the same cycle as the limit is a normal completion and does not set the error.
  - Write data to a timed-out slave is lost.
- **Undefined:**
  - No counter is built.
  - BUSY waits indefinitely.
  - `timeout_err` is tied to 0.

## Test plan
- **Single read:** `m_req`={1, 0x100, 0, 0} at cycle 0; slave `ready`=1 with `rdata`=0xCAFEF00D at cycle 1.
  - `s_req.valid`=1 in cycle 1 only.
  - `m_resp`={0xCAFEF00D, 1} in cycle 2 only.
- **Request lock:** `addr` changes from 0x100 to 0x200 at cycle 2 while the slave stalls until cycle 5.
  - `s_req.addr` stays 0x100 through cycle 5.
  - `ready` reaches the master in cycle 6.
- **Back-to-back writes:** `valid` held high with `wstrb`=0xF and the slave always ready.
  - A new `s_req.valid` every 3 cycles.
  - Exactly one `m_resp.ready` pulse per transaction.
- **Reset mid-BUSY:** `rst`=1 at cycle 2 of a stalled transaction.
  - Cycle 3: `s_req`=0, `m_resp`=0.
  - The FSM accepts a new request at cycle 4.
- **Timeout, macro defined:** `TIMEOUT`=4 and the slave never ready.
  - `m_resp`={0, 1} exactly once, after 4 BUSY cycles.
  - `timeout_err`=1 and stays at 1.
- **Boundary, macro defined:** slave `ready` on the 4th BUSY cycle.
  - Normal completion with slave `rdata`.
  - `timeout_err`=0.
